// File: rtl/mem_controller.sv
`default_nettype none
// ============================================================================
// Module   : mem_controller
// Purpose  : Arbitrates per-consumer memory read/write requests onto a set of
//            external memory channels and relays ready/data back.
// Revision : 1.0 - initial release
// ============================================================================
module mem_controller #(
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter bit WRITE_ENABLE  = 1'b1
) (
    input  logic                                    clk,
    input  logic                                    reset,

    input  logic [NUM_CONSUMERS-1:0]                consumer_read_request,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_request,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,

    output logic [NUM_CHANNELS-1:0]                 mem_read_request,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_request,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

    localparam int CONS_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        S_IDLE           = 3'd0,
        S_READ_WAITING   = 3'd1,
        S_WRITE_WAITING  = 3'd2,
        S_READ_RELAYING  = 3'd3,
        S_WRITE_RELAYING = 3'd4
    } state_t;

    state_t                                  state_q    [NUM_CHANNELS];
    state_t                                  state_d    [NUM_CHANNELS];
    logic [CONS_W-1:0]                       consumer_q [NUM_CHANNELS];
    logic [CONS_W-1:0]                       consumer_d [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]                serving_q, serving_d;
    logic [NUM_CHANNELS-1:0]                 mem_rd_req_q, mem_rd_req_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_rd_addr_q, mem_rd_addr_d;
    logic [NUM_CHANNELS-1:0]                 mem_wr_req_q, mem_wr_req_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_wr_addr_q, mem_wr_addr_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_wr_data_q, mem_wr_data_d;
    logic [NUM_CONSUMERS-1:0]                rd_ready_q, rd_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;
    logic [NUM_CONSUMERS-1:0]                wr_ready_q, wr_ready_d;

    logic [NUM_CONSUMERS-1:0]                w_write_request;
    logic [NUM_CONSUMERS-1:0]                w_claimed;
    logic                                    w_found;

    assign w_write_request = WRITE_ENABLE ? consumer_write_request : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch]    <= S_IDLE;
                consumer_q[ch] <= '0;
            end
            serving_q     <= '0;
            mem_rd_req_q  <= '0;
            mem_rd_addr_q <= '0;
            mem_wr_req_q  <= '0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            rd_ready_q    <= '0;
            rd_data_q     <= '0;
            wr_ready_q    <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch]    <= state_d[ch];
                consumer_q[ch] <= consumer_d[ch];
            end
            serving_q     <= serving_d;
            mem_rd_req_q  <= mem_rd_req_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            mem_wr_req_q  <= mem_wr_req_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            rd_ready_q    <= rd_ready_d;
            rd_data_q     <= rd_data_d;
            wr_ready_q    <= wr_ready_d;
        end
    end

    always_comb begin
        serving_d     = serving_q;
        mem_rd_req_d  = mem_rd_req_q;
        mem_rd_addr_d = mem_rd_addr_q;
        mem_wr_req_d  = mem_wr_req_q;
        mem_wr_addr_d = mem_wr_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        rd_ready_d    = rd_ready_q;
        rd_data_d     = rd_data_q;
        wr_ready_d    = wr_ready_q;
        // Claims are checked against the registered mask plus earlier channels'
        // claims, so a consumer released this cycle cannot be re-claimed yet.
        w_claimed     = serving_q;
        w_found       = 1'b0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_d[ch]    = state_q[ch];
            consumer_d[ch] = consumer_q[ch];
        end

        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state_q[ch])
                S_IDLE: begin
                    w_found = 1'b0;
                    for (int i = 0; i < NUM_CONSUMERS; i++) begin
                        if (!w_found && !w_claimed[i]) begin
                            if (consumer_read_request[i]) begin
                                w_found            = 1'b1;
                                w_claimed[i]       = 1'b1;
                                serving_d[i]       = 1'b1;
                                consumer_d[ch]     = CONS_W'(i);
                                state_d[ch]        = S_READ_WAITING;
                                mem_rd_req_d[ch]   = 1'b1;
                                mem_rd_addr_d[ch]  = consumer_read_address[i];
                            end else if (w_write_request[i]) begin
                                w_found            = 1'b1;
                                w_claimed[i]       = 1'b1;
                                serving_d[i]       = 1'b1;
                                consumer_d[ch]     = CONS_W'(i);
                                state_d[ch]        = S_WRITE_WAITING;
                                mem_wr_req_d[ch]   = 1'b1;
                                mem_wr_addr_d[ch]  = consumer_write_address[i];
                                mem_wr_data_d[ch]  = consumer_write_data[i];
                            end
                        end
                    end
                end
                S_READ_WAITING: begin
                    if (mem_read_ready[ch]) begin
                        mem_rd_req_d[ch]          = 1'b0;
                        rd_ready_d[consumer_q[ch]] = 1'b1;
                        rd_data_d[consumer_q[ch]]  = mem_read_data[ch];
                        state_d[ch]               = S_READ_RELAYING;
                    end
                end
                S_WRITE_WAITING: begin
                    if (mem_write_ready[ch]) begin
                        mem_wr_req_d[ch]          = 1'b0;
                        wr_ready_d[consumer_q[ch]] = 1'b1;
                        state_d[ch]               = S_WRITE_RELAYING;
                    end
                end
                S_READ_RELAYING: begin
                    if (!consumer_read_request[consumer_q[ch]]) begin
                        rd_ready_d[consumer_q[ch]] = 1'b0;
                        serving_d[consumer_q[ch]]  = 1'b0;
                        state_d[ch]               = S_IDLE;
                    end
                end
                S_WRITE_RELAYING: begin
                    if (!w_write_request[consumer_q[ch]]) begin
                        wr_ready_d[consumer_q[ch]] = 1'b0;
                        serving_d[consumer_q[ch]]  = 1'b0;
                        state_d[ch]               = S_IDLE;
                    end
                end
                default: begin
                    state_d[ch] = S_IDLE;
                end
            endcase
        end
    end

    assign consumer_read_ready = rd_ready_q;
    assign consumer_read_data  = rd_data_q;
    assign mem_read_request    = mem_rd_req_q;
    assign mem_read_address    = mem_rd_addr_q;

    generate
        if (WRITE_ENABLE) begin : g_write
            assign consumer_write_ready = wr_ready_q;
            assign mem_write_request    = mem_wr_req_q;
            assign mem_write_address    = mem_wr_addr_q;
            assign mem_write_data       = mem_wr_data_q;
        end else begin : g_no_write
            assign consumer_write_ready = '0;
            assign mem_write_request    = '0;
            assign mem_write_address    = '0;
            assign mem_write_data       = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_controller
// Purpose  : Self-checking bench for mem_controller (1- and 2-channel builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_controller;

    logic clk;
    logic reset;

    // Single-channel instance
    logic [3:0]      a_crr, a_cwr, a_crrdy, a_cwrdy;
    logic [3:0][7:0] a_cra, a_cwa, a_cwd, a_crd;
    logic [0:0]      a_mrq, a_mwq, a_mrr, a_mwr;
    logic [0:0][7:0] a_mra, a_mwa, a_mwd, a_mrd;

    // Two-channel instance
    logic [3:0]      b_crr, b_cwr, b_crrdy, b_cwrdy;
    logic [3:0][7:0] b_cra, b_cwa, b_cwd, b_crd;
    logic [1:0]      b_mrq, b_mwq, b_mrr, b_mwr;
    logic [1:0][7:0] b_mra, b_mwa, b_mwd, b_mrd;

    mem_controller #(
        .NUM_CONSUMERS(4), .NUM_CHANNELS(1), .ADDR_BITS(8), .DATA_BITS(8), .WRITE_ENABLE(1'b1)
    ) u_dut_a (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_request  (a_crr),
        .consumer_read_address  (a_cra),
        .consumer_read_ready    (a_crrdy),
        .consumer_read_data     (a_crd),
        .consumer_write_request (a_cwr),
        .consumer_write_address (a_cwa),
        .consumer_write_data    (a_cwd),
        .consumer_write_ready   (a_cwrdy),
        .mem_read_request       (a_mrq),
        .mem_read_address       (a_mra),
        .mem_read_ready         (a_mrr),
        .mem_read_data          (a_mrd),
        .mem_write_request      (a_mwq),
        .mem_write_address      (a_mwa),
        .mem_write_data         (a_mwd),
        .mem_write_ready        (a_mwr)
    );

    mem_controller #(
        .NUM_CONSUMERS(4), .NUM_CHANNELS(2), .ADDR_BITS(8), .DATA_BITS(8), .WRITE_ENABLE(1'b1)
    ) u_dut_b (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_request  (b_crr),
        .consumer_read_address  (b_cra),
        .consumer_read_ready    (b_crrdy),
        .consumer_read_data     (b_crd),
        .consumer_write_request (b_cwr),
        .consumer_write_address (b_cwa),
        .consumer_write_data    (b_cwd),
        .consumer_write_ready   (b_cwrdy),
        .mem_read_request       (b_mrq),
        .mem_read_address       (b_mra),
        .mem_read_ready         (b_mrr),
        .mem_read_data          (b_mrd),
        .mem_write_request      (b_mwq),
        .mem_write_address      (b_mwa),
        .mem_write_data         (b_mwd),
        .mem_write_ready        (b_mwr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Behavioural memory behind the single-channel instance, and the
    // reference view of memory contents as seen by completed transactions.
    logic [7:0] mem_a   [256];
    logic [7:0] ref_mem [256];
    int         lat_a;
    bit         rand_lat;
    int         rcnt, wcnt;

    logic [3:0] rd_pend, wr_pend;
    int         order[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: ready pulses after the request has been seen lat_a+1 times.
    initial begin
        a_mrr = '0; a_mwr = '0; a_mrd = '0;
        rcnt = 0; wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            a_mrr = '0;
            a_mwr = '0;
            if (a_mrq[0] === 1'b1) begin
                rcnt++;
                if (rcnt > lat_a) begin
                    a_mrr[0] = 1'b1;
                    a_mrd[0] = mem_a[a_mra[0]];
                    rcnt = 0;
                    if (rand_lat) lat_a = $urandom_range(0, 3);
                end
            end else begin
                rcnt = 0;
            end
            if (a_mwq[0] === 1'b1) begin
                wcnt++;
                if (wcnt > lat_a) begin
                    a_mwr[0] = 1'b1;
                    mem_a[a_mwa[0]] = a_mwd[0];
                    wcnt = 0;
                    if (rand_lat) lat_a = $urandom_range(0, 3);
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic start_read(input int i, input logic [7:0] addr);
        a_cra[i] = addr;
        a_crr[i] = 1'b1;
        rd_pend[i] = 1'b1;
    endtask

    task automatic start_write(input int i, input logic [7:0] addr, input logic [7:0] data);
        a_cwa[i] = addr;
        a_cwd[i] = data;
        a_cwr[i] = 1'b1;
        wr_pend[i] = 1'b1;
    endtask

    // One cycle of consumer behaviour: complete handshakes against the
    // reference memory, optionally launch new random requests.
    task automatic service_cycle(input bit gen);
        step();
        chk("ready_onehot", {31'b0, ($countones({a_crrdy, a_cwrdy}) <= 1)}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (a_crrdy[i]) begin
                chk("rd_ready_unexpected", {31'b0, rd_pend[i]}, 32'd1);
                if (rd_pend[i]) begin
                    chk("rd_data", {24'b0, a_crd[i]}, {24'b0, ref_mem[a_cra[i]]});
                    order.push_back(i);
                    a_crr[i]   = 1'b0;
                    rd_pend[i] = 1'b0;
                end
            end
            if (a_cwrdy[i]) begin
                chk("wr_ready_unexpected", {31'b0, wr_pend[i]}, 32'd1);
                if (wr_pend[i]) begin
                    chk("wr_mem", {24'b0, mem_a[a_cwa[i]]}, {24'b0, a_cwd[i]});
                    ref_mem[a_cwa[i]] = a_cwd[i];
                    order.push_back(10 + i);
                    a_cwr[i]   = 1'b0;
                    wr_pend[i] = 1'b0;
                end
            end
            if (gen && !rd_pend[i] && !a_crrdy[i] && $urandom_range(0, 3) == 0)
                start_read(i, 8'($urandom_range(0, 15)));
            if (gen && !wr_pend[i] && !a_cwrdy[i] && $urandom_range(0, 5) == 0)
                start_write(i, 8'($urandom_range(0, 15)), 8'($urandom));
        end
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((rd_pend | wr_pend) != 4'b0 && n < max) begin
            service_cycle(1'b0);
            n++;
        end
        chk("drain_timeout", {28'b0, rd_pend | wr_pend}, 32'd0);
        service_cycle(1'b0);
        service_cycle(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        a_crr = '0; a_cwr = '0; a_cra = '0; a_cwa = '0; a_cwd = '0;
        b_crr = '0; b_cwr = '0; b_cra = '0; b_cwa = '0; b_cwd = '0;
        b_mrr = '0; b_mwr = '0; b_mrd = '0;
        rd_pend = '0; wr_pend = '0;
        lat_a = 0; rand_lat = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i]   = 8'($urandom);
            ref_mem[i] = mem_a[i];
        end
        #1 reset = 1'b0;
        #1;
        // Reset state, before any clock edge
        chk("rst_a_consumer", {a_crrdy, a_cwrdy, a_crd[1:0]}, 32'd0);
        chk("rst_a_mem", {a_mrq, a_mwq, a_mra[0], a_mwa[0], a_mwd[0]}, 32'd0);
        chk("rst_b_consumer", {b_crrdy, b_cwrdy, b_crd[1:0]}, 32'd0);
        chk("rst_b_mem", {b_mrq, b_mwq, b_mra}, 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // Single read: consumer 2 reads 0x3C, memory answers on first request cycle
        mem_a[8'h3C] = 8'hA5; ref_mem[8'h3C] = 8'hA5;
        a_cra[2] = 8'h3C; a_crr[2] = 1'b1;
        step();
        chk("rd1_mem_req", {23'b0, a_mrq, a_mra[0]}, {23'b0, 1'b1, 8'h3C});
        chk("rd1_not_ready", {28'b0, a_crrdy}, 32'd0);
        step();
        chk("rd1_ready", {28'b0, a_crrdy}, 32'h4);
        chk("rd1_data", {24'b0, a_crd[2]}, 32'hA5);
        chk("rd1_mem_req_drop", {31'b0, a_mrq}, 32'd0);
        step();
        chk("rd1_ready_held", {28'b0, a_crrdy}, 32'h4);
        a_crr[2] = 1'b0;
        step();
        chk("rd1_ready_drop", {28'b0, a_crrdy}, 32'd0);
        chk("rd1_data_hold", {24'b0, a_crd[2]}, 32'hA5);

        // Single write: consumer 1 writes 0x7E to 0x10, memory answers after 2 request cycles
        lat_a = 1;
        a_cwa[1] = 8'h10; a_cwd[1] = 8'h7E; a_cwr[1] = 1'b1;
        step();
        chk("wr1_mem_req", {15'b0, a_mwq, a_mwa[0], a_mwd[0]}, {15'b0, 1'b1, 8'h10, 8'h7E});
        step();
        chk("wr1_not_ready", {28'b0, a_cwrdy}, 32'd0);
        chk("wr1_req_held", {31'b0, a_mwq}, 32'd1);
        step();
        chk("wr1_ready", {28'b0, a_cwrdy}, 32'h2);
        chk("wr1_mem_req_drop", {31'b0, a_mwq}, 32'd0);
        chk("wr1_mem_content", {24'b0, mem_a[8'h10]}, 32'h7E);
        ref_mem[8'h10] = 8'h7E;
        a_cwr[1] = 1'b0;
        step();
        chk("wr1_ready_drop", {28'b0, a_cwrdy}, 32'd0);
        chk("rd_never_during_wr", {31'b0, a_mrq}, 32'd0);

        // Contention: all four read at once on one channel
        rand_lat = 1'b1; lat_a = 2;
        order.delete();
        for (int i = 0; i < 4; i++) start_read(i, 8'($urandom_range(0, 255)));
        drain(200);
        chk("cont_count", order.size(), 32'd4);
        for (int k = 0; k < order.size(); k++) chk("cont_order", order[k], k);

        // Read and write on the same consumer: read first, write after
        order.delete();
        rand_lat = 1'b0; lat_a = 0;
        start_read(1, 8'h20);
        start_write(1, 8'h20, ~ref_mem[8'h20]);
        step();
        chk("rw_read_first", {30'b0, a_mrq, a_mwq}, 32'h2);
        drain(100);
        chk("rw_count", order.size(), 32'd2);
        if (order.size() == 2) begin
            chk("rw_first_read", order[0], 32'd1);
            chk("rw_then_write", order[1], 32'd11);
        end

        // Two channels: consumers 0 and 3 claimed concurrently by channels 0 and 1
        b_cra[0] = 8'h11; b_cra[3] = 8'h33; b_crr = 4'b1001;
        step();
        chk("ch2_reqs", {30'b0, b_mrq}, 32'h3);
        chk("ch2_addrs", {16'b0, b_mra[1], b_mra[0]}, 32'h3311);
        chk("ch2_no_ready", {28'b0, b_crrdy}, 32'd0);
        b_mrd[0] = 8'hAA; b_mrd[1] = 8'hBB; b_mrr = 2'b11;
        step();
        b_mrr = 2'b00;
        chk("ch2_ready", {28'b0, b_crrdy}, 32'h9);
        chk("ch2_data", {16'b0, b_crd[3], b_crd[0]}, 32'hBBAA);
        chk("ch2_req_drop", {30'b0, b_mrq}, 32'd0);
        b_crr = 4'b0000;
        step();
        chk("ch2_ready_drop", {28'b0, b_crrdy}, 32'd0);
        chk("ch2_no_write", {30'b0, b_mwq}, 32'd0);

        // Randomised traffic on the single-channel instance
        rand_lat = 1'b1; lat_a = 1;
        order.delete();
        for (int c = 0; c < 400; c++) service_cycle(1'b1);
        drain(300);

        // Asynchronous reset during READ_WAITING
        rand_lat = 1'b0; lat_a = 8;
        start_read(0, 8'h05);
        step();
        chk("rst_mid_waiting", {31'b0, a_mrq}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_consumer", {a_crrdy, a_cwrdy, a_crd[1:0]}, 32'd0);
        chk("rst_mid_mem", {a_mrq, a_mwq, a_mra[0], a_mwa[0], a_mwd[0]}, 32'd0);
        a_crr = '0; a_cwr = '0; rd_pend = '0; wr_pend = '0;
        step();
        reset = 1'b1;
        step();
        lat_a = 0;
        order.delete();
        start_read(3, 8'h3C);
        drain(50);
        chk("post_rst_count", order.size(), 32'd1);
        if (order.size() == 1) chk("post_rst_consumer", order[0], 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
